// File: rtl/mem_responder.sv
// Fixed-latency 64-bit word memory responder with valid/ready request and response channels.
// Optional build macro MEMRSP_ALIGN_CHECK_EN rejects requests whose byte address is not word aligned.
module mem_responder #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          DATA_W = 64;
  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
`ifdef MEMRSP_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic              wen_p0;
  logic [63:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [7:0]        wmask_p0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              c_wen;
  logic [63:0]       c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [7:0]        c_wmask;
  logic [63:0]       c_off;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic              c_err;
  logic [DATA_W-1:0] c_rdata;
  logic              unused_ok;

  // Subtraction is only trusted after the lower-bound test, so the offset never wraps.
  function automatic logic addr_in_range(input logic [63:0] a);
    logic [63:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) && (off < (64'd8 << DEPTH_LOG2));
  endfunction

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With single-cycle latency the accepting edge is also the commit edge, so use the live request.
  assign commit  = !rst && ((accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1)));
  assign c_wen   = (state == IDLE) ? req_wen   : wen_p0;
  assign c_addr  = (state == IDLE) ? req_addr  : addr_p0;
  assign c_wdata = (state == IDLE) ? req_wdata : wdata_p0;
  assign c_wmask = (state == IDLE) ? req_wmask : wmask_p0;
  assign c_off   = c_addr - ADDR_BASE;
  assign c_idx   = c_off[DEPTH_LOG2+2:3];
  assign c_err   = !addr_in_range(c_addr) || (ALIGN_CHK && (c_addr[2:0] != 3'd0));
  assign c_rdata = (c_err || c_wen) ? '0 : mem[c_idx];
  assign unused_ok = ^{c_off[2:0], c_off[63:DEPTH_LOG2+3]};

  // p0: request capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_p0   <= req_wen;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      wmask_p0 <= req_wmask;
    end
  end

  // commit: byte-masked array update
  always_ff @(posedge clk) begin
    if (commit && c_wen && !c_err) begin
      for (int i = 0; i < 8; i++) begin
        if (c_wmask[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_rdata <= c_rdata;
              rsp_err   <= c_err;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            cnt       <= 4'd0;
            rsp_rdata <= c_rdata;
            rsp_err   <= c_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected responses, a negedge monitor checks them.
module tb_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [64:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BASE(64'h8000_0000), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: accept-to-valid latency and response contents
  int   ncyc = 0;
  int   acc_cyc = 0;
  bit   pend = 1'b0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    logic [64:0] e;
    ncyc++;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (rsp_valid && !prev_vld && pend) begin
        chk("latency", 64'(ncyc - acc_cyc), 64'(LAT));
        pend = 1'b0;
      end
      if (req_valid && req_ready) begin
        pend = 1'b1;
        acc_cyc = ncyc;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[63:0]);
          chk("rsp_err", 64'(rsp_err), 64'(e[64]));
        end
      end
    end
    prev_vld = rsp_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic wen, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                      input bit push, input logic [63:0] er, input logic ee);
    int t = 0;
    if (push) exp_q.push_back({ee, er});
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clk);
    while (!req_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0, expected 1 within 40 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold_rdata;
    logic        hold_err;
    int          t;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Basic write then read
    send(1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 1, 64'd0, 1'b0); drain();
    send(1'b0, 64'h8000_0000, 64'd0, 8'h00, 1, 64'h1122_3344_5566_7788, 1'b0); drain();

    // Partial byte mask
    send(1'b1, 64'h8000_0008, 64'd0, 8'hFF, 1, 64'd0, 1'b0); drain();
    send(1'b1, 64'h8000_0008, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 1, 64'd0, 1'b0); drain();
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 1, 64'h0000_0000_EEFF_0011, 1'b0); drain();

    // Empty mask is a no-op write
    send(1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 64'd0, 1'b0); drain();
    send(1'b0, 64'h8000_0000, 64'd0, 8'h00, 1, 64'h1122_3344_5566_7788, 1'b0); drain();

    // Backpressure: response held while a new request waits
    rsp_ready = 1'b0;
    send(1'b0, 64'h8000_0000, 64'd0, 8'h00, 1, 64'h1122_3344_5566_7788, 1'b0);
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    hold_rdata = rsp_rdata;
    hold_err   = rsp_err;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0008; req_wmask = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_rdata", rsp_rdata, hold_rdata);
      chk("stall_rsp_err", 64'(rsp_err), 64'(hold_err));
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00, 1, 64'h0000_0000_EEFF_0011, 1'b0); drain();

    // Range boundaries and no aliasing
    send(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 1, 64'd0, 1'b1); drain();
    send(1'b0, 64'h8000_2000, 64'd0, 8'h00, 1, 64'd0, 1'b1); drain();
    send(1'b1, 64'h8000_2000, 64'h0000_0000_0000_DEAD, 8'hFF, 1, 64'd0, 1'b1); drain();
    send(1'b0, 64'h8000_0000, 64'd0, 8'h00, 1, 64'h1122_3344_5566_7788, 1'b0); drain();
    send(1'b1, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'd0, 1'b0); drain();
    send(1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 1, 64'h0123_4567_89AB_CDEF, 1'b0); drain();

    // Reset drops an in-flight write
    send(1'b1, 64'h8000_0010, 64'h33, 8'hFF, 1, 64'd0, 1'b0); drain();
    send(1'b1, 64'h8000_0010, 64'h55, 8'hFF, 0, 64'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("inrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("inrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("postrst_rsp_valid2", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    send(1'b0, 64'h8000_0010, 64'd0, 8'h00, 1, 64'h33, 1'b0); drain();

    // Misaligned address
`ifdef MEMRSP_ALIGN_CHECK_EN
    send(1'b0, 64'h8000_0004, 64'd0, 8'h00, 1, 64'd0, 1'b1); drain();
`else
    send(1'b0, 64'h8000_0004, 64'd0, 8'h00, 1, 64'h1122_3344_5566_7788, 1'b0); drain();
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
